// File: rtl/cordic_channel_scheduler.sv
// rtl/cordic_channel_scheduler.sv - round-robin front end that shares one vectoring CORDIC across NUM_CH channels.
// Optional watchdog on lost results: CORDIC_SCHED_TIMEOUT_EN (adds TIMEOUT parameter and ERR_TIMEOUT port).
module cordic_channel_scheduler #(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 48,
  parameter int TAG_DEPTH = 32
`ifdef CORDIC_SCHED_TIMEOUT_EN
  , parameter int TIMEOUT = 256
`endif
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [NUM_CH-1:0]            S_VALID,
  output logic [NUM_CH-1:0]            S_READY,
  input  logic [NUM_CH*DATA_W-1:0]     S_X,
  input  logic [NUM_CH*DATA_W-1:0]     S_Y,
  input  logic                         FLUSH,
  output logic                         FLUSH_DONE,
  output logic                         C_RST,
  output logic                         C_DIN_VALID,
  output logic [DATA_W-1:0]            C_DIN_X,
  output logic [DATA_W-1:0]            C_DIN_Y,
  input  logic                         C_DOUT_VALID,
  input  logic [DATA_W-1:0]            C_DOUT_X,
  input  logic [DATA_W-1:0]            C_DOUT_A,
  output logic                         M_VALID,
  output logic [$clog2(NUM_CH)-1:0]    M_CH,
  output logic [DATA_W-1:0]            M_MAG,
  output logic [DATA_W-1:0]            M_PHASE,
  output logic                         BUSY,
  output logic                         ERR_ORPHAN
`ifdef CORDIC_SCHED_TIMEOUT_EN
  , output logic                       ERR_TIMEOUT
`endif
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TAG_DEPTH);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE, ST_HOLD} state_t;

  state_t              state_q, state_d;
  logic [CH_W-1:0]     last_grant_q, last_grant_d;
  logic [CNT_W-1:0]    outstanding_q, outstanding_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CH_W-1:0]     tag_mem_q [TAG_DEPTH];
  logic [CH_W-1:0]     tag_mem_d [TAG_DEPTH];
  logic                c_din_valid_q, c_din_valid_d;
  logic [DATA_W-1:0]   c_din_x_q, c_din_x_d;
  logic [DATA_W-1:0]   c_din_y_q, c_din_y_d;
  logic                m_valid_q, m_valid_d;
  logic [CH_W-1:0]     m_ch_q, m_ch_d;
  logic [DATA_W-1:0]   m_mag_q, m_mag_d;
  logic [DATA_W-1:0]   m_phase_q, m_phase_d;
  logic                err_orphan_q, err_orphan_d;
  logic                flush_done_q, flush_done_d;

  logic [DATA_W-1:0]   s_x_arr [NUM_CH];
  logic [DATA_W-1:0]   s_y_arr [NUM_CH];
  logic [CH_W:0]       cand_sum;
  logic [CH_W-1:0]     cand;
  logic [CH_W-1:0]     grant_idx;
  logic                found;
  logic                grant_ok;
  logic                transfer;
  logic                fifo_empty;
  logic                pop;
  logic                orphan;
  logic                tmo_fire;

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      s_x_arr[k] = S_X[k*DATA_W +: DATA_W];
      s_y_arr[k] = S_Y[k*DATA_W +: DATA_W];
    end
  end

  // Search starts one past the last winner and wraps, giving strict rotation.
  always_comb begin
    found     = 1'b0;
    grant_idx = last_grant_q;
    cand_sum  = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand_sum = {1'b0, last_grant_q} + (CH_W+1)'(i);
      if (cand_sum >= (CH_W+1)'(NUM_CH)) begin
        cand_sum = cand_sum - (CH_W+1)'(NUM_CH);
      end
      cand = cand_sum[CH_W-1:0];
      if (!found && S_VALID[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign fifo_empty = (outstanding_q == '0);
  assign pop        = C_DOUT_VALID && !fifo_empty;
  assign orphan     = C_DOUT_VALID && fifo_empty;
  assign grant_ok   = !RST && (state_q == ST_RUN) && (outstanding_q < FULL_CNT) && !tmo_fire;
  assign transfer   = grant_ok && found;

  always_comb begin
    S_READY = '0;
    if (transfer) begin
      S_READY[grant_idx] = 1'b1;
    end
  end

`ifdef CORDIC_SCHED_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             err_timeout_q, err_timeout_d;

  assign tmo_fire = !fifo_empty && !C_DOUT_VALID && (tmo_cnt_q == TMO_W'(TIMEOUT - 1));

  always_comb begin
    tmo_cnt_d     = (fifo_empty || C_DOUT_VALID) ? '0 : tmo_cnt_q + 1'b1;
    err_timeout_d = err_timeout_q;
    if (tmo_fire) begin
      tmo_cnt_d     = '0;
      err_timeout_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      tmo_cnt_q     <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q     <= tmo_cnt_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign ERR_TIMEOUT = err_timeout_q;
`else
  assign tmo_fire = 1'b0;
`endif

  always_comb begin
    last_grant_d  = last_grant_q;
    outstanding_d = outstanding_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    tag_mem_d     = tag_mem_q;
    c_din_valid_d = transfer;
    c_din_x_d     = c_din_x_q;
    c_din_y_d     = c_din_y_q;
    m_valid_d     = pop;
    m_ch_d        = m_ch_q;
    m_mag_d       = m_mag_q;
    m_phase_d     = m_phase_q;
    err_orphan_d  = err_orphan_q | orphan;

    if (transfer) begin
      last_grant_d        = grant_idx;
      c_din_x_d           = s_x_arr[grant_idx];
      c_din_y_d           = s_y_arr[grant_idx];
      tag_mem_d[wr_ptr_q] = grant_idx;
      wr_ptr_d            = wr_ptr_q + 1'b1;
    end

    if (pop) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      m_ch_d    = tag_mem_q[rd_ptr_q];
      m_mag_d   = C_DOUT_X;
      m_phase_d = C_DOUT_A;
    end

    case ({transfer, pop})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase

    // A watchdog expiry abandons everything in flight; late results become orphans.
    if (tmo_fire) begin
      outstanding_d = '0;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
    end
  end

  always_comb begin
    state_d      = state_q;
    flush_done_d = 1'b0;
    case (state_q)
      ST_RUN:   if (FLUSH) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (fifo_empty) begin
          state_d      = ST_DONE;
          flush_done_d = 1'b1;
        end
      end
      ST_DONE:  state_d = ST_HOLD;
      ST_HOLD:  if (!FLUSH) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= ST_RUN;
      last_grant_q  <= CH_W'(NUM_CH - 1);
      outstanding_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      c_din_valid_q <= 1'b0;
      c_din_x_q     <= '0;
      c_din_y_q     <= '0;
      m_valid_q     <= 1'b0;
      m_ch_q        <= '0;
      m_mag_q       <= '0;
      m_phase_q     <= '0;
      err_orphan_q  <= 1'b0;
      flush_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      outstanding_q <= outstanding_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      c_din_valid_q <= c_din_valid_d;
      c_din_x_q     <= c_din_x_d;
      c_din_y_q     <= c_din_y_d;
      m_valid_q     <= m_valid_d;
      m_ch_q        <= m_ch_d;
      m_mag_q       <= m_mag_d;
      m_phase_q     <= m_phase_d;
      err_orphan_q  <= err_orphan_d;
      flush_done_q  <= flush_done_d;
    end
  end

  // Tag storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge CLK) begin
    tag_mem_q <= tag_mem_d;
  end

  assign C_RST       = RST;
  assign C_DIN_VALID = c_din_valid_q;
  assign C_DIN_X     = c_din_x_q;
  assign C_DIN_Y     = c_din_y_q;
  assign M_VALID     = m_valid_q;
  assign M_CH        = m_ch_q;
  assign M_MAG       = m_mag_q;
  assign M_PHASE     = m_phase_q;
  assign BUSY        = !fifo_empty;
  assign ERR_ORPHAN  = err_orphan_q;
  assign FLUSH_DONE  = flush_done_q;

endmodule

// File: tb/tb_cordic_channel_scheduler.sv
// tb/tb_cordic_channel_scheduler.sv - directed bench with an 18-cycle CORDIC stand-in.
module tb_cordic_channel_scheduler;
  localparam int NUM_CH    = 4;
  localparam int DATA_W    = 48;
  localparam int TAG_DEPTH = 32;
  localparam int LAT       = 18;

  logic                     CLK;
  logic                     RST;
  logic [NUM_CH-1:0]        S_VALID;
  logic [NUM_CH-1:0]        S_READY;
  logic [NUM_CH*DATA_W-1:0] S_X;
  logic [NUM_CH*DATA_W-1:0] S_Y;
  logic                     FLUSH;
  logic                     FLUSH_DONE;
  logic                     C_RST;
  logic                     C_DIN_VALID;
  logic [DATA_W-1:0]        C_DIN_X;
  logic [DATA_W-1:0]        C_DIN_Y;
  logic                     C_DOUT_VALID;
  logic [DATA_W-1:0]        C_DOUT_X;
  logic [DATA_W-1:0]        C_DOUT_A;
  logic                     M_VALID;
  logic [1:0]               M_CH;
  logic [DATA_W-1:0]        M_MAG;
  logic [DATA_W-1:0]        M_PHASE;
  logic                     BUSY;
  logic                     ERR_ORPHAN;
`ifdef CORDIC_SCHED_TIMEOUT_EN
  logic                     ERR_TIMEOUT;
`endif

  cordic_channel_scheduler #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .TAG_DEPTH(TAG_DEPTH)
`ifdef CORDIC_SCHED_TIMEOUT_EN
    , .TIMEOUT(64)
`endif
  ) dut (
    .CLK(CLK), .RST(RST), .S_VALID(S_VALID), .S_READY(S_READY), .S_X(S_X), .S_Y(S_Y),
    .FLUSH(FLUSH), .FLUSH_DONE(FLUSH_DONE), .C_RST(C_RST), .C_DIN_VALID(C_DIN_VALID),
    .C_DIN_X(C_DIN_X), .C_DIN_Y(C_DIN_Y), .C_DOUT_VALID(C_DOUT_VALID), .C_DOUT_X(C_DOUT_X),
    .C_DOUT_A(C_DOUT_A), .M_VALID(M_VALID), .M_CH(M_CH), .M_MAG(M_MAG), .M_PHASE(M_PHASE),
    .BUSY(BUSY), .ERR_ORPHAN(ERR_ORPHAN)
`ifdef CORDIC_SCHED_TIMEOUT_EN
    , .ERR_TIMEOUT(ERR_TIMEOUT)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // CORDIC stand-in: magnitude = isqrt(x^2+y^2), angle = y, fixed latency.
  logic              pipe_v [LAT];
  logic [DATA_W-1:0] pipe_m [LAT];
  logic [DATA_W-1:0] pipe_a [LAT];
  logic              model_en;
  logic              inj_v;

  function automatic logic [DATA_W-1:0] isqrt(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y);
    logic [63:0] s;
    logic [63:0] r;
    s = 64'(x[15:0]) * 64'(x[15:0]) + 64'(y[15:0]) * 64'(y[15:0]);
    r = 0;
    while ((r + 1) * (r + 1) <= s) r = r + 1;
    return DATA_W'(r);
  endfunction

  always @(posedge CLK) begin
    if (C_RST) begin
      for (int i = 0; i < LAT; i++) pipe_v[i] <= 1'b0;
    end else begin
      pipe_v[0] <= C_DIN_VALID & model_en;
      pipe_m[0] <= isqrt(C_DIN_X, C_DIN_Y);
      pipe_a[0] <= C_DIN_Y;
      for (int i = 1; i < LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_m[i] <= pipe_m[i-1];
        pipe_a[i] <= pipe_a[i-1];
      end
    end
  end

  assign C_DOUT_VALID = pipe_v[LAT-1] | inj_v;
  assign C_DOUT_X     = pipe_m[LAT-1];
  assign C_DOUT_A     = pipe_a[LAT-1];

  int n_cmp  = 0;
  int n_fail = 0;
  int n, got, grants, results, pulses, bad_grants, last_m, done_cyc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    RST = 1'b1; S_VALID = '0; S_X = '0; S_Y = '0; FLUSH = 1'b0;
    model_en = 1'b1; inj_v = 1'b0;
    repeat (3) tick();
    S_VALID = '1;
    #1;
    check("rst_s_ready", S_READY, 0);
    check("rst_c_rst", C_RST, 1);
    S_VALID = '0;
    RST = 1'b0;
    #1;
    check("rst_m_valid", M_VALID, 0);
    check("rst_c_din_valid", C_DIN_VALID, 0);
    check("rst_busy", BUSY, 0);
    check("rst_flush_done", FLUSH_DONE, 0);
    check("rst_err_orphan", ERR_ORPHAN, 0);
    check("rst_c_rst_low", C_RST, 0);
    check("rst_m_mag", M_MAG, 0);

    // Single sample on channel 2
    S_X[2*DATA_W +: DATA_W] = 48'd3;
    S_Y[2*DATA_W +: DATA_W] = 48'd4;
    S_VALID = 4'b0100;
    #1;
    check("single_ready", S_READY, 4'b0100);
    tick();
    S_VALID = '0;
    check("single_din_valid", C_DIN_VALID, 1);
    check("single_din_x", C_DIN_X, 3);
    check("single_din_y", C_DIN_Y, 4);
    check("single_busy", BUSY, 1);
    n = 0;
    while (!M_VALID && n < 40) begin tick(); n++; end
    check("single_latency", n, 19);
    check("single_ch", M_CH, 2);
    check("single_mag", M_MAG, 5);
    check("single_phase", M_PHASE, 4);
    check("single_busy_after", BUSY, 0);
    tick();
    check("single_m_valid_pulse", M_VALID, 0);

    // Round-robin with all channels valid, starting fresh from reset
    RST = 1'b1;
    tick();
    RST = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      S_X[k*DATA_W +: DATA_W] = DATA_W'(10 + k);
      S_Y[k*DATA_W +: DATA_W] = DATA_W'(1000 + k);
    end
    S_VALID = 4'hF;
    #1;
    for (int i = 0; i < 16; i++) begin
      check("rr_grant", S_READY, 64'(1) << (i % 4));
      tick();
    end
    S_VALID = '0;
    got = 0; n = 0;
    while (got < 16 && n < 60) begin
      tick(); n++;
      if (M_VALID) begin
        check("rr_ch", M_CH, got % 4);
        check("rr_phase", M_PHASE, 1000 + got % 4);
        got++;
      end
    end
    check("rr_count", got, 16);

    // Flush with nothing outstanding
    FLUSH = 1'b1;
    tick();
    check("flush_idle_t1", FLUSH_DONE, 0);
    tick();
    check("flush_idle_t2", FLUSH_DONE, 1);
    tick();
    check("flush_idle_t3", FLUSH_DONE, 0);
    S_VALID = 4'hF;
    #1;
    check("hold_no_grant", S_READY, 0);
    S_VALID = '0;
    FLUSH = 1'b0;
    tick();

    // Flush with 10 outstanding on channel 0
    S_VALID = 4'b0001;
    repeat (10) tick();
    S_VALID = '0;
    FLUSH = 1'b1;
    check("flush_busy", BUSY, 1);
    tick();
    S_VALID = 4'hF;
    results = 0; pulses = 0; bad_grants = 0; last_m = -1; done_cyc = -1;
    for (int cyc = 0; cyc < 80; cyc++) begin
      #1;
      if (S_READY != '0) bad_grants++;
      if (M_VALID) begin results++; last_m = cyc; end
      if (FLUSH_DONE) begin pulses++; done_cyc = cyc; end
      tick();
    end
    check("flush_results", results, 10);
    check("flush_pulses", pulses, 1);
    check("flush_no_grants", bad_grants, 0);
    check("flush_done_after_last", done_cyc, last_m + 1);
    FLUSH = 1'b0;
    tick();
    #1;
    check("flush_resume", S_READY, 4'b0010);
    S_VALID = '0;
    tick();

    // Credit exhaustion with CORDIC output withheld
    model_en = 1'b0;
    S_VALID = 4'hF;
    grants = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (S_READY != '0) grants++;
      tick();
    end
    check("credit_grants", grants, TAG_DEPTH);
    check("credit_full_ready", S_READY, 0);
    check("credit_full_busy", BUSY, 1);
    inj_v = 1'b1;
    #1;
    check("credit_same_cycle", S_READY, 0);
    tick();
    inj_v = 1'b0;
    #1;
    check("credit_next_cycle", $countones(S_READY), 1);
    check("credit_pop_result", M_VALID, 1);
    tick();
    #1;
    check("credit_full_again", S_READY, 0);

    // Reset mid-operation, then orphan detection
    RST = 1'b1;
    #1;
    check("rst2_c_rst", C_RST, 1);
    check("rst2_s_ready", S_READY, 0);
    tick();
    RST = 1'b0;
    S_VALID = '0;
    model_en = 1'b1;
    #1;
    check("rst2_busy", BUSY, 0);
    check("rst2_din_valid", C_DIN_VALID, 0);
    inj_v = 1'b1;
    tick();
    inj_v = 1'b0;
    #1;
    check("orphan_flag", ERR_ORPHAN, 1);
    check("orphan_no_m_valid", M_VALID, 0);
    check("orphan_busy", BUSY, 0);
    tick();
    check("orphan_sticky", ERR_ORPHAN, 1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    #1;
    check("orphan_cleared", ERR_ORPHAN, 0);
    check("rst3_busy", BUSY, 0);

`ifdef CORDIC_SCHED_TIMEOUT_EN
    model_en = 1'b0;
    S_VALID = 4'b0001;
    repeat (3) tick();
    S_VALID = '0;
    check("tmo_busy", BUSY, 1);
    n = 0;
    while (!ERR_TIMEOUT && n < 200) begin tick(); n++; end
    check("tmo_flag", ERR_TIMEOUT, 1);
    check("tmo_busy_cleared", BUSY, 0);
    check("tmo_window", (n >= 60 && n <= 66), 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/cordic_channel_scheduler.md
Name: cordic_channel_scheduler

Overview:
- Time-shares the single vectoring-mode CORDIC (48-bit X/Y in, magnitude DOUT_X and angle DOUT_A out) among NUM_CH I/Q channels of the envelope detector.
- Arbitrates requesters round-robin and feeds the CORDIC at up to one sample per cycle.
- Tracks the channel of each in-flight sample in a tag FIFO, since the CORDIC carries no tag, and re-labels every result with its channel.
- Provides a flush sequence for reconfiguration.

Parameters:
- NUM_CH, 4, number of requesting channels (2..16); CH_W = clog2(NUM_CH) is derived.
- DATA_W, 48, I/Q and result width; must match CORECORDIC IN_BITS/OUT_BITS.
- TAG_DEPTH, 32, tag FIFO depth and maximum outstanding samples; power of two, must be at least the CORDIC pipeline latency.

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous active-high reset
- S_VALID  in  NUM_CH  per-channel sample valid
- S_READY  out  NUM_CH  per-channel grant, one-hot or zero
- S_X  in  NUM_CH*DATA_W  I samples; channel k uses bits [k*DATA_W +: DATA_W]
- S_Y  in  NUM_CH*DATA_W  Q samples, same packing
- FLUSH  in  1  level request: stop granting and drain
- FLUSH_DONE  out  1  single-cycle pulse when drained
- C_RST  out  1  CORDIC reset, equal to RST combinationally
- C_DIN_VALID  out  1  to CORDIC DIN_VALID
- C_DIN_X  out  DATA_W  to CORDIC DIN_X
- C_DIN_Y  out  DATA_W  to CORDIC DIN_Y
- C_DOUT_VALID  in  1  from CORDIC DOUT_VALID
- C_DOUT_X  in  DATA_W  CORDIC magnitude
- C_DOUT_A  in  DATA_W  CORDIC angle
- M_VALID  out  1  result valid; no backpressure, downstream must accept
- M_CH  out  CH_W  channel of result
- M_MAG  out  DATA_W  magnitude
- M_PHASE  out  DATA_W  angle
- BUSY  out  1  outstanding != 0
- ERR_ORPHAN  out  1  sticky: C_DOUT_VALID arrived with tag FIFO empty

Behaviour:
- Reset: all outputs 0; last_grant = NUM_CH-1; tag FIFO and outstanding counter cleared; state RUN. C_RST clears the CORDIC pipeline in the same cycle, so no stale results appear after reset. Reset mid-operation drops all in-flight samples silently.
- Grant conditions:
  - A grant occurs when state == RUN and outstanding < TAG_DEPTH.
  - It goes to the first channel with S_VALID set, searching from last_grant+1 with wrap-around.
  - S_READY is combinational from S_VALID, state, outstanding and last_grant. At most one bit is set.
  - Transfer happens when S_VALID[k] & S_READY[k]; last_grant updates to k.
- Issue:
  - On transfer, the next cycle registers C_DIN_VALID=1 and C_DIN_X/C_DIN_Y from the channel's sample.
  - The channel id is pushed into the tag FIFO in that same cycle. Otherwise C_DIN_VALID=0 and data holds.
  - Fairness: with all channels valid, grants rotate 0,1,2,3,0,… at one per cycle.
- Credits:
  - outstanding increments on a grant and decrements on C_DOUT_VALID with a non-empty FIFO.
  - A simultaneous grant and pop leaves the count unchanged.
  - A credit freed by a pop is usable in the next cycle, not the same one.
  - At outstanding == TAG_DEPTH no grants occur.
- Return:
  - On C_DOUT_VALID, pop the tag. The next cycle drives M_VALID=1, M_CH=tag, M_MAG=C_DOUT_X, M_PHASE=C_DOUT_A. Latency is 1 cycle.
  - If the FIFO is empty, ERR_ORPHAN goes to 1 (cleared only by RST), M_VALID stays 0 and the result is discarded.
- FSM:
  - RUN: grants allowed. FLUSH=1 moves to DRAIN.
  - DRAIN: S_READY=0, results still returned. outstanding==0 (including the in-flight issue register) moves to DONE.
  - DONE: FLUSH_DONE=1 for one cycle, then HOLD.
  - HOLD: stays while FLUSH=1; FLUSH=0 returns to RUN.
  - FLUSH asserted with nothing outstanding goes RUN→DRAIN→DONE, so FLUSH_DONE pulses 2 cycles after FLUSH rises.
- Arithmetic: data passes through unmodified; no width conversion.

Optional Feature:
- Macro CORDIC_SCHED_TIMEOUT_EN, with parameter TIMEOUT, default 256.
- When defined:
  - A counter runs while outstanding != 0 and resets on each C_DOUT_VALID.
  - Reaching TIMEOUT clears the tag FIFO and outstanding, and sets sticky output ERR_TIMEOUT.
  - Later results then count as orphans.
- When undefined: no counter, no ERR_TIMEOUT port, and outstanding may stay non-zero indefinitely.

Test Plan:
- Single channel, model latency 18: S_VALID[2] with X=48'd3, Y=48'd4 → C_DIN_VALID 1 cycle later. Model returns 5 → M_VALID at issue+19, M_CH=2, M_MAG=5.
- All 4 channels continuously valid for 16 cycles → grant order 0,1,2,3 repeating. Results return with M_CH in the same order, each channel 4 times.
- TAG_DEPTH=32 with CORDIC output withheld → exactly 32 grants, then S_READY=0. One C_DOUT_VALID → one further grant on the following cycle.
- FLUSH raised with 10 outstanding → no grants after FLUSH; 10 results delivered; FLUSH_DONE pulses once after the last. Deasserting FLUSH resumes grants.
- C_DOUT_VALID injected with empty FIFO → ERR_ORPHAN=1, M_VALID stays 0. RST clears ERR_ORPHAN, S_READY, BUSY, and asserts C_RST.
- With CORDIC_SCHED_TIMEOUT_EN and TIMEOUT=64: 3 issued, no returns → ERR_TIMEOUT at 64 idle cycles, BUSY=0.
